vid_line_out: RTL and testbench

Line-memory read-side streamer for the video pipeline. On a start pulse it reads one stored line of 4:2:2 pixel pairs (32-bit words, Cb Y0 Cr Y1) from the dual-buffer line memory's read port. It serializes them into an 8-bit byte stream with a valid/ready handshake and first/last markers. It sits between the line memory and the video output PHY/encoder, and runs entirely in the memory's read clock domain.

---
 rtl/vid_line_out.sv | 220 ++++++++++++++++++++++
 tb/tb_vid_line_out.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vid_line_out.sv
// vid_line_out: streams one line of 32-bit 4:2:2 pixel pairs from line memory as valid/ready bytes.
// Optional BT.656 SAV/EAV framing around the pixel bytes is enabled by defining VID_LINE_OUT_BT656_EN.
module vid_line_out #(
  parameter int PAIRS_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               buf_sel,
  input  logic [PAIRS_W-1:0] len,
  input  logic [1:0]         fvh,
  output logic               mem_buf_0,
  output logic [PAIRS_W-1:0] mem_pix_0,
  input  logic [31:0]        mem_data_1,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_first,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

`ifdef VID_LINE_OUT_BT656_EN
  localparam bit FRAMED = 1'b1;
  logic [1:0] fvh_reg;

  function automatic logic [7:0] code_byte(input logic [1:0] idx, input logic [1:0] fv, input logic h);
    logic f;
    logic v;
    f = fv[1];
    v = fv[0];
    case (idx)
      2'd0:    code_byte = 8'hFF;
      2'd3:    code_byte = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
      default: code_byte = 8'h00;
    endcase
  endfunction
`else
  localparam bit FRAMED = 1'b0;
  logic unused_fvh;
  assign unused_fvh = ^fvh;
`endif

  typedef enum logic [2:0] {IDLE, SAV, DATA, EAV, DONE} state_t;
  state_t state_reg;

  logic [PAIRS_W-1:0] reads_left_reg;
  logic [PAIRS_W-1:0] pops_left_reg;
  logic               rd_vld_reg;
  logic [31:0]        fifo_mem [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         fifo_cnt_reg;
  logic [23:0]        word_reg;
  logic [1:0]         byte_idx_reg;
  logic               last_word_reg;
  logic               first_pend_reg;

  logic        hs;
  logic        head_avail;
  logic [31:0] head_word;
  logic        want_word;
  logic        take;
  logic        push;
  logic        pop;
  logic        issue;

  assign hs         = out_valid & out_ready;
  assign head_avail = (fifo_cnt_reg != 2'd0) | rd_vld_reg;
  // An empty FIFO lets the returning read bypass straight into the serializer.
  assign head_word  = (fifo_cnt_reg != 2'd0) ? fifo_mem[rd_ptr_reg] : mem_data_1;
  assign want_word  = (pops_left_reg != '0) &&
                      (((state_reg == DATA) && (!out_valid || (out_ready && byte_idx_reg == 2'd3))) ||
                       ((state_reg == SAV) && hs && byte_idx_reg == 2'd3));
  assign take       = want_word & head_avail;
  assign pop        = take & (fifo_cnt_reg != 2'd0);
  assign push       = rd_vld_reg & ~(take & (fifo_cnt_reg == 2'd0));
  assign issue      = ((state_reg == SAV) || (state_reg == DATA) || (state_reg == EAV)) &&
                      (reads_left_reg != '0) &&
                      (({1'b0, fifo_cnt_reg} + {2'b00, rd_vld_reg}) < 3'd2);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem_data_1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      reads_left_reg <= '0;
      pops_left_reg  <= '0;
      rd_vld_reg     <= 1'b0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      fifo_cnt_reg   <= 2'd0;
      word_reg       <= '0;
      byte_idx_reg   <= 2'd0;
      last_word_reg  <= 1'b0;
      first_pend_reg <= 1'b0;
      mem_buf_0      <= 1'b0;
      mem_pix_0      <= '0;
      out_data       <= 8'h00;
      out_valid      <= 1'b0;
      out_first      <= 1'b0;
      out_last       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef VID_LINE_OUT_BT656_EN
      fvh_reg        <= 2'b00;
`endif
    end else begin
      done       <= 1'b0;
      rd_vld_reg <= issue;
      if (issue) begin
        reads_left_reg <= reads_left_reg - PAIRS_W'(1);
        if (reads_left_reg != PAIRS_W'(1)) mem_pix_0 <= mem_pix_0 + PAIRS_W'(1);
      end
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, pop};

      case (state_reg)
        IDLE: if (start) begin
          mem_buf_0      <= buf_sel;
          mem_pix_0      <= '0;
          reads_left_reg <= len;
          pops_left_reg  <= len;
          wr_ptr_reg     <= 1'b0;
          rd_ptr_reg     <= 1'b0;
          fifo_cnt_reg   <= 2'd0;
          busy           <= 1'b1;
`ifdef VID_LINE_OUT_BT656_EN
          fvh_reg        <= fvh;
          state_reg      <= SAV;
          out_valid      <= 1'b1;
          out_data       <= 8'hFF;
          out_first      <= 1'b1;
          byte_idx_reg   <= 2'd0;
`else
          first_pend_reg <= 1'b1;
          if (len == '0) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            state_reg <= DATA;
          end
`endif
        end
`ifdef VID_LINE_OUT_BT656_EN
        SAV: if (hs) begin
          out_first <= 1'b0;
          if (byte_idx_reg != 2'd3) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
            out_data     <= code_byte(byte_idx_reg + 2'd1, fvh_reg, 1'b0);
          end else if (pops_left_reg == '0) begin
            state_reg    <= EAV;
            out_data     <= 8'hFF;
            byte_idx_reg <= 2'd0;
          end else begin
            state_reg <= DATA;
            out_valid <= 1'b0;
          end
        end
        EAV: if (hs) begin
          if (byte_idx_reg != 2'd3) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
            out_data     <= code_byte(byte_idx_reg + 2'd1, fvh_reg, 1'b1);
            out_last     <= (byte_idx_reg == 2'd2);
          end else begin
            state_reg <= DONE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
`endif
        DATA: if (hs && !take) begin
          out_first <= 1'b0;
          if (byte_idx_reg != 2'd3) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
            out_data     <= word_reg[{byte_idx_reg, 3'b000} +: 8];
            out_last     <= !FRAMED && last_word_reg && (byte_idx_reg == 2'd2);
          end else if (last_word_reg) begin
            out_last <= 1'b0;
`ifdef VID_LINE_OUT_BT656_EN
            state_reg    <= EAV;
            out_data     <= 8'hFF;
            byte_idx_reg <= 2'd0;
`else
            state_reg <= DONE;
            out_valid <= 1'b0;
            done      <= 1'b1;
`endif
          end else begin
            out_valid <= 1'b0;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase

      // Serializer load: byte 0 goes out now, bytes 1..3 are kept for the following handshakes.
      if (take) begin
        word_reg       <= head_word[31:8];
        out_data       <= head_word[7:0];
        out_valid      <= 1'b1;
        out_first      <= first_pend_reg;
        out_last       <= 1'b0;
        byte_idx_reg   <= 2'd0;
        pops_left_reg  <= pops_left_reg - PAIRS_W'(1);
        last_word_reg  <= (pops_left_reg == PAIRS_W'(1));
        first_pend_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vid_line_out.sv
// Randomized bench for vid_line_out: byte stream checked against a queue model built from the memory image.
module tb_vid_line_out;
  localparam int PW = 9;
`ifdef VID_LINE_OUT_BT656_EN
  localparam int PRE = 4;
`else
  localparam int PRE = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          buf_sel;
  logic [PW-1:0] len;
  logic [1:0]    fvh;
  logic          mem_buf_0;
  logic [PW-1:0] mem_pix_0;
  logic [31:0]   mem_data_1;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic          busy;
  logic          done;

  vid_line_out #(.PAIRS_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .buf_sel(buf_sel), .len(len), .fvh(fvh),
    .mem_buf_0(mem_buf_0), .mem_pix_0(mem_pix_0), .mem_data_1(mem_data_1),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line memory: registered read, data valid the cycle after the address.
  logic [31:0] mem [2][512];
  always @(posedge clk) mem_data_1 <= mem[mem_buf_0][mem_pix_0];

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] lit_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check_eq(tag, {out_valid, out_first, out_last, busy, done, mem_buf_0, out_data, mem_pix_0}, 32'd0);
  endtask

`ifdef VID_LINE_OUT_BT656_EN
  function automatic logic [7:0] xy_ref(input logic [1:0] fv, input int h);
    int f;
    int v;
    f = int'(fv[1]);
    v = int'(fv[0]);
    return 8'(128 + f * 64 + v * 32 + h * 16 + ((v + h) % 2) * 8 + ((f + h) % 2) * 4 +
              ((f + v) % 2) * 2 + ((f + v + h) % 2));
  endfunction
`endif

  function automatic void build_exp(input int l, input bit b, input logic [1:0] fv);
    logic [31:0] w;
    exp_q.delete();
`ifdef VID_LINE_OUT_BT656_EN
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(xy_ref(fv, 0));
`endif
    for (int i = 0; i < l; i++) begin
      w = mem[b][i];
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
    end
`ifdef VID_LINE_OUT_BT656_EN
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(xy_ref(fv, 1));
`endif
  endfunction

  task automatic cmp_lit(input string tag);
    check_eq({tag, "_len"}, got_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < got_q.size(); i++) check_eq(tag, got_q[i], lit_q[i]);
  endtask

  // mode 0: ready always high, 1: toggling with 5-cycle stalls, 2: random ready.
  task automatic run_line(input int len_i, input bit buf_i, input logic [1:0] fvh_i, input int mode,
                          input int restart_cyc, input int abort_byte);
    int n, cyc, loaded, stall, total, lim, p, exp_done, done_cyc;
    bit prev_stall, tog, fin, aborted;
    logic [7:0] pd;
    logic pf, pl;
    build_exp(len_i, buf_i, fvh_i);
    total = exp_q.size();
    got_q.delete();
    lim = 8 * (total + 4) + 100;
    exp_done = (PRE != 0) ? 4 * len_i + 9 : ((len_i == 0) ? 1 : 4 * len_i + 3);
    n = 0; cyc = 0; loaded = 0; stall = 0; done_cyc = -1;
    prev_stall = 0; tog = 0; fin = 0; aborted = 0;
    pd = 8'h00; pf = 1'b0; pl = 1'b0;
    @(negedge clk);
    start = 1'b1; buf_sel = buf_i; len = len_i[PW-1:0]; fvh = fvh_i; out_ready = 1'b1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == restart_cyc) begin
        start = 1'b1; buf_sel = ~buf_i; len = 9'd7; fvh = ~fvh_i;
      end
      if (mode == 1) begin
        if (stall > 0) begin out_ready = 1'b0; stall--; end
        else if ($urandom_range(0, 15) == 0) begin out_ready = 1'b0; stall = 4; end
        else begin tog = ~tog; out_ready = tog; end
      end else if (mode == 2) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      if (prev_stall) check_eq("hold", {out_valid, out_first, out_last, out_data}, {1'b1, pf, pl, pd});
      prev_stall = 0;
      if (out_valid) begin
        if (n >= total) begin
          check_eq("byte_count", n + 1, total);
        end else begin
          check_eq("data", out_data, exp_q[n]);
          check_eq("first", out_first, n == 0);
          check_eq("last", out_last, n == total - 1);
          p = n - PRE;
          if (p >= 0 && p < 4 * len_i && p % 4 == 0 && p / 4 + 1 > loaded) loaded = p / 4 + 1;
        end
        if (out_ready) begin
          got_q.push_back(out_data);
          n++;
        end else begin
          prev_stall = 1; pd = out_data; pf = out_first; pl = out_last;
        end
      end
      check_eq("inflight", int'(mem_pix_0) <= loaded + 2, 1);
      check_eq("mem_buf", mem_buf_0, buf_i);
      if (!done) check_eq("busy", busy, 1);
      if (done) begin
        done_cyc = cyc;
        fin = 1;
        check_eq("byte_count", n, total);
        if (mode == 0) check_eq("done_cycle", cyc, exp_done);
      end else if (abort_byte >= 0 && n == abort_byte) begin
        #2 rst_n = 1'b0;
        #1 check_rst("rst_async");
        @(negedge clk);
        check_rst("rst_hold");
        rst_n = 1'b1;
        fin = 1; aborted = 1;
      end else if (cyc > lim) begin
        check_eq("timeout", cyc, lim);
        fin = 1;
      end
    end
    if (!aborted) begin
      for (int t = 0; t < 3; t++) begin
        @(negedge clk);
        check_eq("done_once", done, 0);
        check_eq("tail_valid", out_valid, 0);
        check_eq("tail_busy", busy, 0);
      end
    end
    $display("line len=%0d buf=%0d mode=%0d bytes=%0d done_cycle=%0d aborted=%0d",
             len_i, buf_i, mode, n, done_cyc, aborted);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; buf_sel = 1'b0; len = '0; fvh = 2'b00; out_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++) mem[b][a] = $urandom;
    #3 rst_n = 1'b0;
    #1 check_rst("rst_init");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    mem[1][0] = 32'h44332211;
    mem[1][1] = 32'h88776655;
    lit_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_line(2, 1'b1, 2'b00, 0, -1, -1);
`ifndef VID_LINE_OUT_BT656_EN
    cmp_lit("tp_basic");
`endif
    run_line(2, 1'b1, 2'b00, 1, -1, -1);
`ifndef VID_LINE_OUT_BT656_EN
    cmp_lit("tp_stall");
`endif

`ifdef VID_LINE_OUT_BT656_EN
    mem[0][0] = 32'hDDCCBBAA;
    lit_q = '{8'hFF, 8'h00, 8'h00, 8'hAB, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'h00, 8'h00, 8'hB6};
    run_line(1, 1'b0, 2'b01, 0, -1, -1);
    cmp_lit("tp_bt656");
`endif

    run_line(0, 1'b0, 2'b10, 0, -1, -1);
    check_eq("len0_addr", mem_pix_0, 0);

    for (int i = 0; i < 8; i++)
      run_line($urandom_range(1, 40), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               (i % 2) + 1, -1, -1);

    run_line(360, 1'b0, 2'b11, 0, 100, -1);
    run_line(360, 1'b1, 2'b00, 0, -1, 500);
    run_line(1, 1'b0, 2'b01, 0, -1, -1);
    run_line(511, 1'b1, 2'b10, 2, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
